// File: rtl/instrumented_adder_if.sv
// Control, operand and result signals of the instrumented adder, grouped so the
// register wrapper above (master) and the measurement block (slave) share one bundle.
//   stop_b, extra_inverter, bypass_b, control_b : ring configuration
//   a_input_ext_bit_b, a_input_ring_bit_b,
//   s_output_bit_b                             : per-bit, active-low path selects
//   counter_enable, counter_load,
//   integration_time                           : integration window control
//   a_input, b_input                           : adder operands
//   sum_out, done, ring_osc_counter_out        : results
interface instrumented_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stop_b;
  logic             extra_inverter;
  logic             bypass_b;
  logic             control_b;
  logic [WIDTH-1:0] a_input_ext_bit_b;
  logic [WIDTH-1:0] a_input_ring_bit_b;
  logic [WIDTH-1:0] s_output_bit_b;
  logic             counter_enable;
  logic             counter_load;
  logic [WIDTH-1:0] integration_time;
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic [WIDTH-1:0] sum_out;
  logic             done;
  logic [WIDTH-1:0] ring_osc_counter_out;

  modport master (
    output stop_b, extra_inverter, bypass_b, control_b,
    output a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b,
    output counter_enable, counter_load, integration_time,
    output a_input, b_input,
    input  sum_out, done, ring_osc_counter_out
  );

  modport slave (
    input  stop_b, extra_inverter, bypass_b, control_b,
    input  a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b,
    input  counter_enable, counter_load, integration_time,
    input  a_input, b_input,
    output sum_out, done, ring_osc_counter_out
  );
endinterface

// File: rtl/instrumented_adder.sv
// Delay-measurement block: a WIDTH-bit adder embedded in a configurable ring
// oscillator. A toggle flop plus ripple counter measure the ring (or a fixed
// 3-inverter reference ring) while a clk-domain down counter sets the window.
//   clk   : system clock, drives the integration counter
//   reset : asynchronous active-high, clears both counters and the toggle flop
//   bus   : instrumented_adder_if slave modport (controls, operands, results)
module instrumented_adder #(
  parameter int unsigned WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  instrumented_adder_if.slave bus
);

  // Ring nets. Each ring gate carries one time unit of delay in simulation so
  // the loop oscillates; the delays are ignored by synthesis and the nets are
  // kept so the loop is not optimised away.
  (* keep = "true", dont_touch = "true" *) logic             ring;
  (* keep = "true", dont_touch = "true" *) logic             ring_ret;
  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] a_eff;
  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] sum;
  (* keep = "true", dont_touch = "true" *) logic             ref0;
  (* keep = "true", dont_touch = "true" *) logic             ref1;
  (* keep = "true", dont_touch = "true" *) logic             ref2;

  // Adder operand: each bit picks the external operand, the ring node, or both
  // (OR) depending on the two active-low selects.
  assign #1 a_eff = (~bus.a_input_ext_bit_b & bus.a_input) |
                    (~bus.a_input_ring_bit_b & {WIDTH{ring}});
  assign #1 sum   = a_eff + bus.b_input;
  assign bus.sum_out = sum;

  // Loop return: OR of the selected sum bits, or straight back when bypassed.
  assign #1 ring_ret = bus.bypass_b ? |(sum & ~bus.s_output_bit_b) : ring;
  // Inverting stage; extra_inverter flips the loop parity, stop_b parks it at 0.
  assign #1 ring     = bus.stop_b & ~(ring_ret ^ bus.extra_inverter);

  // Fixed 3-inverter reference ring.
  assign #1 ref0 = bus.stop_b & ~ref2;
  assign #1 ref1 = ~ref0;
  assign #1 ref2 = ~ref1;

  logic meas_src;
  assign meas_src = bus.control_b ? ring : ref0;

  // Integration window counter (clk domain).
  logic [WIDTH-1:0] int_count_q;
  logic             done;

  assign done     = (int_count_q == '0);
  assign bus.done = done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_count_q <= '0;
    end else if (bus.counter_load) begin
      int_count_q <= bus.integration_time;
    end else if (bus.counter_enable && !done) begin
      int_count_q <= int_count_q - 1'b1;
    end
  end

  // Divide-by-two of the measured source; its rising edge advances the count,
  // so the counter holds source cycles / 2.
  logic toggle_q;

  always_ff @(posedge meas_src or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= ~toggle_q;
    end
  end

  // The gate is sampled directly in the ring domain; a window edge landing
  // close to a toggle edge costs at most one count.
  logic             count_gate;
  logic [WIDTH-1:0] ring_count_q;

  assign count_gate = bus.counter_enable & ~done;

  always_ff @(posedge toggle_q or posedge reset) begin
    if (reset) begin
      ring_count_q <= '0;
    end else if (count_gate) begin
      ring_count_q <= ring_count_q + 1'b1;
    end
  end

  assign bus.ring_osc_counter_out = ring_count_q;

endmodule

// File: tb/tb_instrumented_adder.sv
// Directed self-checking bench for instrumented_adder: adder function with the
// ring stopped, bit masking, integration window timing, ring count behaviour
// for the bypass loop, the adder loop and the reference ring, and reset
// asserted in the middle of a window.
module tb_instrumented_adder;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  instrumented_adder_if #(.WIDTH(WIDTH)) bus ();

  instrumented_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] c_bypass;
  logic [31:0] c_adder;

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #2;
  endtask

  // Load n, enable counting, wait for done, then let two more clk cycles pass
  // before sampling the ring count.
  task automatic run_window(input logic [31:0] n, input string name, output logic [31:0] cnt);
    int waited;
    @(negedge clk);
    bus.counter_load     = 1'b1;
    bus.integration_time = n;
    bus.counter_enable   = 1'b0;
    @(negedge clk);
    bus.counter_load   = 1'b0;
    bus.counter_enable = 1'b1;
    waited = 0;
    while (bus.done !== 1'b1 && waited < int'(n) + 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_window_timeout: done=%b required 1", name, bus.done);
    end
    repeat (2) @(posedge clk);
    #1;
    cnt = bus.ring_osc_counter_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL reset_done: got %b required 1", bus.done);
    end
    checks++;
    if (bus.ring_osc_counter_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", bus.ring_osc_counter_out);
    end
    reset = 1'b0;
    #2;
  endtask

  task automatic test_adder();
    logic [31:0] av [4] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bv [4] = '{32'd7, 32'd1, 32'h8000_0000, 32'h1111_1111};
    logic [31:0] ev [4] = '{32'd12, 32'd0, 32'd0, 32'h2345_6789};
    bus.stop_b             = 1'b0;
    bus.a_input_ring_bit_b = '1;
    bus.a_input_ext_bit_b  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.a_input = av[i];
      bus.b_input = bv[i];
      #4;
      checks++;
      if (bus.sum_out !== ev[i]) begin
        errors++;
        $display("FAIL adder_%0d: got %h required %h", i, bus.sum_out, ev[i]);
      end
    end
  endtask

  task automatic test_mask();
    bus.stop_b             = 1'b0;
    bus.a_input_ring_bit_b = '1;
    bus.a_input_ext_bit_b  = 32'hFFFF_FFFE;
    bus.a_input            = 32'h0000_00FF;
    bus.b_input            = 32'd0;
    #4;
    checks++;
    if (bus.sum_out !== 32'd1) begin
      errors++;
      $display("FAIL mask_bit0: got %h required 00000001", bus.sum_out);
    end
    bus.a_input_ext_bit_b = '1;
    bus.b_input           = 32'd3;
    #4;
    checks++;
    if (bus.sum_out !== 32'd3) begin
      errors++;
      $display("FAIL mask_all: got %h required 00000003", bus.sum_out);
    end
  endtask

  task automatic test_window();
    logic exp_done;
    pulse_reset();
    @(negedge clk);
    bus.counter_load     = 1'b1;
    bus.integration_time = 32'd10;
    bus.counter_enable   = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL window_after_load: done=%b required 0", bus.done);
    end
    @(negedge clk);
    bus.counter_load   = 1'b0;
    bus.counter_enable = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk);
      #1;
      exp_done = (i >= 10);
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL window_edge_%0d: done=%b required %b", i, bus.done, exp_done);
      end
    end
    bus.counter_enable = 1'b0;
  endtask

  task automatic test_stopped_ring();
    logic [31:0] cnt;
    pulse_reset();
    bus.stop_b    = 1'b0;
    bus.control_b = 1'b1;
    bus.bypass_b  = 1'b0;
    run_window(32'd20, "stopped", cnt);
    checks++;
    if (cnt !== 32'd0) begin
      errors++;
      $display("FAIL stopped_count: got %0d required 0", cnt);
    end
    bus.counter_enable = 1'b0;
  endtask

  // Bypass loop: two unit gates per half period -> period 4, ~1000 units of
  // window -> about 125 toggle-flop rising edges.
  task automatic test_running_ring();
    logic [31:0] later;
    pulse_reset();
    bus.a_input_ext_bit_b  = '1;
    bus.a_input_ring_bit_b = '1;
    bus.s_output_bit_b     = '1;
    bus.b_input            = '0;
    bus.bypass_b           = 1'b0;
    bus.extra_inverter     = 1'b0;
    bus.control_b          = 1'b1;
    bus.stop_b             = 1'b1;
    #20;
    run_window(32'd100, "bypass", c_bypass);
    checks++;
    if (c_bypass < 32'd100 || c_bypass > 32'd150) begin
      errors++;
      $display("FAIL bypass_count: got %0d required 100..150", c_bypass);
    end
    repeat (20) @(posedge clk);
    #1;
    later = bus.ring_osc_counter_out;
    checks++;
    if (later !== c_bypass) begin
      errors++;
      $display("FAIL bypass_frozen: got %0d required %0d", later, c_bypass);
    end
    bus.counter_enable = 1'b0;
  endtask

  // Adder loop on bit 0: four unit gates per half period -> roughly half the
  // bypass count.
  task automatic test_adder_ring();
    pulse_reset();
    bus.stop_b             = 1'b0;
    #10;
    bus.a_input_ext_bit_b  = '1;
    bus.a_input_ring_bit_b = 32'hFFFF_FFFE;
    bus.s_output_bit_b     = 32'hFFFF_FFFE;
    bus.b_input            = '0;
    bus.bypass_b           = 1'b1;
    bus.extra_inverter     = 1'b0;
    bus.control_b          = 1'b1;
    bus.stop_b             = 1'b1;
    #20;
    run_window(32'd100, "adder", c_adder);
    checks++;
    if (c_adder >= c_bypass || c_adder == 32'd0) begin
      errors++;
      $display("FAIL adder_vs_bypass: got %0d required 0 < count < %0d", c_adder, c_bypass);
    end
    checks++;
    if (c_adder < 32'd50 || c_adder > 32'd75) begin
      errors++;
      $display("FAIL adder_count: got %0d required 50..75", c_adder);
    end
    bus.counter_enable = 1'b0;
  endtask

  // Reference ring: three unit inverters -> period 6, about 83 counts.
  task automatic test_reference_ring();
    logic [31:0] cnt;
    pulse_reset();
    bus.control_b = 1'b0;
    bus.stop_b    = 1'b1;
    #20;
    run_window(32'd100, "reference", cnt);
    checks++;
    if (cnt < 32'd70 || cnt > 32'd95) begin
      errors++;
      $display("FAIL reference_count: got %0d required 70..95", cnt);
    end
    bus.counter_enable = 1'b0;
    bus.control_b      = 1'b1;
  endtask

  task automatic test_reset_mid_window();
    pulse_reset();
    bus.bypass_b  = 1'b0;
    bus.control_b = 1'b1;
    bus.stop_b    = 1'b1;
    #20;
    @(negedge clk);
    bus.counter_load     = 1'b1;
    bus.integration_time = 32'd10;
    bus.counter_enable   = 1'b0;
    @(negedge clk);
    bus.counter_load   = 1'b0;
    bus.counter_enable = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_before_reset_done: got %b required 0", bus.done);
    end
    checks++;
    if (bus.ring_osc_counter_out == 32'd0) begin
      errors++;
      $display("FAIL mid_before_reset_count: got 0 required nonzero");
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_done: got %b required 1", bus.done);
    end
    checks++;
    if (bus.ring_osc_counter_out !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_count: got %0d required 0", bus.ring_osc_counter_out);
    end
    reset = 1'b0;
    bus.counter_enable = 1'b0;
    @(negedge clk);
    bus.counter_load     = 1'b1;
    bus.integration_time = 32'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL load_zero_done: got %b required 1", bus.done);
    end
    bus.counter_load = 1'b0;
    bus.stop_b       = 1'b0;
  endtask

  initial begin
    reset                  = 1'b0;
    bus.stop_b             = 1'b0;
    bus.extra_inverter     = 1'b0;
    bus.bypass_b           = 1'b0;
    bus.control_b          = 1'b1;
    bus.a_input_ext_bit_b  = '1;
    bus.a_input_ring_bit_b = '1;
    bus.s_output_bit_b     = '1;
    bus.counter_enable     = 1'b0;
    bus.counter_load       = 1'b0;
    bus.integration_time   = '0;
    bus.a_input            = '0;
    bus.b_input            = '0;
    #2;
    test_reset();
    test_adder();
    test_mask();
    test_window();
    test_stopped_ring();
    test_running_ring();
    test_adder_ring();
    test_reference_ring();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instrumented_adder.md
# instrumented_adder

Delay-measurement block: a 32-bit adder embedded in a configurable ring oscillator. A frequency counter measures the ring while a gate counter in the system-clock domain sets the integration window. Control and result words are driven and read by the logic-analyzer register wrapper above it; there is no bus interface here.

## Interface
- WIDTH, 32, adder, mask and counter width.
- clk  in  1  system clock; drives the integration counter.
- reset  in  1  async, active-high; clears both counters.
- stop_b  in  1  0 = ring held stopped; 1 = ring free-runs.
- extra_inverter  in  1  1 = insert one extra inverter stage in the ring.
- bypass_b  in  1  0 = ring skips the adder.
- control_b  in  1  0 = counter measures the fixed reference ring instead.
- a_input_ext_bit_b  in  WIDTH  per-bit, active-low: adder a[i] takes a_input[i].
- a_input_ring_bit_b  in  WIDTH  per-bit, active-low: adder a[i] takes the ring node.
- s_output_bit_b  in  WIDTH  per-bit, active-low: sum[i] feeds back to the ring.
- counter_enable  in  1  enables integration.
- counter_load  in  1  loads integration_time.
- integration_time  in  WIDTH  window length in clk cycles.
- a_input, b_input  in  WIDTH  adder operands.
- sum_out  out  WIDTH  adder result.
- done  out  1  high when the integration counter is 0.
- ring_osc_counter_out  out  WIDTH  ring cycles / 2 counted.

## Operation
- Adder a operand, per bit: a_eff[i] = (~a_input_ext_bit_b[i] & a_input[i]) | (~a_input_ring_bit_b[i] & ring).
- Sum: sum_out = a_eff + b_input, modulo 2^WIDTH, carry discarded, purely combinational.
- Ring return:
  - bypass_b=1: ring_ret = OR over i of (sum_out[i] & ~s_output_bit_b[i]).
  - bypass_b=0: ring_ret = ring.
- Ring node: ring_next = stop_b & ~(ring_ret XOR extra_inverter).
  - stop_b=0 forces ring=0.
  - extra_inverter flips loop parity.
- Delay model: every ring gate, including the adder path, carries 1 time unit of delay in simulation. Synthesis marks ring cells keep/dont_touch.
- Reference ring: an independent 3-inverter ring, also gated by stop_b.
- Measured source: ring when control_b=1, reference ring when control_b=0.
  - The source clocks a toggle flop.
  - The toggle flop's rising edge increments ring_osc_counter, so the count is cycles / 2.
- Count gating: increments only while counter_enable=1 and done=0, sampled in the ring domain.
- ring_osc_counter wraps at 2^WIDTH and is cleared only by reset.
- Integration counter (clk domain):
  - counter_load=1: load integration_time. Load has priority over enable.
  - Else if counter_enable=1 and count≠0: decrement by 1.
  - Otherwise hold.
- done = (integration count == 0), combinational from the register.

## Timing
- Reset: integration count=0, done=1, ring_osc_counter_out=0, toggle flop=0. sum_out is combinational and unaffected by reset.
- Load of N at edge k gives done=0 after edge k (for N>0). With enable held, done=1 after edge k+N.
- Load of 0 keeps done=1.
- Reset asserted mid-window: done=1 and counts=0 immediately, asynchronously.
- ring_osc_counter_out is asynchronous to clk. It is valid to read once done=1 and ≥2 clk cycles have elapsed.

## Test plan
- Adder with ring stopped: stop_b=0, ring_bit_b=all 1, ext_bit_b=0, a=5, b=7 -> sum_out=12. a=0xFFFFFFFF, b=1 -> sum_out=0.
- Bit masking: ext_bit_b=0xFFFFFFFE, a=0xFF, b=0 -> sum_out=1.
- Integration window: reset, load integration_time=10, then counter_enable=1 -> done=0 for exactly 10 clk edges, then 1 and stays 1.
- Stopped ring: stop_b=0 through a full window -> ring_osc_counter_out=0.
- Running ring: stop_b=1, bypass_b=0, extra_inverter=0, 100-cycle window -> count >0 and frozen after done.
  - Repeat with the adder path on bit 0 (ring_bit_b[0]=0, s_bit_b[0]=0, b=0) -> count strictly smaller.
- Reset mid-window: after 5 of 10 cycles, pulse reset -> done=1 and ring_osc_counter_out=0 immediately; counter_load with 0 keeps done=1.
